// File: rtl/mem_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_stage_pkg
//   Shared pipeline definitions used by the Memory stage and its neighbours:
//   writeback-source encodings, Tnew width, the EX/MEM control bundle and a
//   helper that ages a Tnew value by one pipeline stage.
// ----------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned TNEW_W    = 2;
    localparam int unsigned MTR_W     = 2;

    // Writeback-source select carried down the pipe.
    typedef enum logic [MTR_W-1:0] {
        MTR_ALU = 2'b00,   // ALU result
        MTR_MEM = 2'b01,   // data-memory read
        MTR_PC8 = 2'b10    // link address (PC+8)
    } memtoReg_e;

    typedef logic [TNEW_W-1:0]    tnew_t;
    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REG_IDX_W-1:0] regIdx_t;

    // Control fields registered at the EX/MEM boundary.
    typedef struct packed {
        logic      regWrite;
        memtoReg_e memtoReg;
        logic      memWrite;
        regIdx_t   writeReg;
        tnew_t     tnew;
    } exMemCtrl_t;

    // Datapath fields registered at the EX/MEM boundary.
    typedef struct packed {
        word_t aluOut;
        word_t writeData;
        word_t pc4;
        word_t extImm;
    } exMemData_t;

    // One stage closer to producing its result; saturates at zero so an
    // already-available result never wraps back to "not ready".
    function automatic tnew_t tnewAge(input tnew_t t);
        tnew_t aged;
        if (t == '0) begin
            aged = '0;
        end else begin
            aged = t - tnew_t'(1);
        end
        return aged;
    endfunction

endpackage : mem_stage_pkg

// File: rtl/mem_stage_dm.sv
// ----------------------------------------------------------------------------
// dm
//   Word-addressed data memory: synchronous write, asynchronous read and a
//   synchronous clear of every word on reset.
//
//   Ports
//     clk    in   clock, all writes on rising edge
//     reset  in   synchronous active-high clear of all words (beats we)
//     we     in   write enable
//     addr   in   word index [ADDR_W-1:0]
//     wd     in   write data
//     rd     out  combinational read of mem[addr] (pre-write value)
// ----------------------------------------------------------------------------
module dm
    import mem_stage_pkg::*;
#(
    parameter int unsigned DM_WORDS = 1024,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wd,
    output logic [WORD_W-1:0] rd
);

    logic [WORD_W-1:0] mem [DM_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DM_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[addr] <= wd;
        end
    end

    // Read is combinational, so a word written at an edge is only seen
    // from the following cycle.
    assign rd = mem[addr];

endmodule : dm

// File: rtl/mem_stage.sv
// ----------------------------------------------------------------------------
// mem_stage
//   Memory stage of the 5-stage pipeline: EX/MEM pipeline register, store-data
//   forwarding mux and the data memory.
//
//   Ports
//     clk, reset              clock; synchronous active-high reset
//     RegWriteE..TnewE        Execute-stage values captured each edge
//     ResultW                 writeback result, forwarded store-data source
//     forwardM                1 = store ResultW, 0 = store WriteDataM
//     RegWriteM, MemtoRegM,
//     WriteRegM, TnewM        registered control to Writeback / hazard unit
//     ALUoutM, PC_4M,
//     ext_immM, WriteDataM    registered datapath values
//     ReadDataM               combinational read of word ALUoutM[ADDR_W+1:2]
// ----------------------------------------------------------------------------
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned DM_WORDS = 1024,
    parameter int unsigned ADDR_W   = 10
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 RegWriteE,
    input  logic [MTR_W-1:0]     MemtoRegE,
    input  logic                 MemWriteE,
    input  logic [WORD_W-1:0]    ALUoutE,
    input  logic [WORD_W-1:0]    WriteDataE,
    input  logic [REG_IDX_W-1:0] WriteRegE,
    input  logic [WORD_W-1:0]    PC_4E,
    input  logic [WORD_W-1:0]    ext_immE,
    input  logic [TNEW_W-1:0]    TnewE,

    input  logic [WORD_W-1:0]    ResultW,
    input  logic                 forwardM,

    output logic                 RegWriteM,
    output logic [MTR_W-1:0]     MemtoRegM,
    output logic [REG_IDX_W-1:0] WriteRegM,
    output logic [TNEW_W-1:0]    TnewM,
    output logic [WORD_W-1:0]    ALUoutM,
    output logic [WORD_W-1:0]    WriteDataM,
    output logic [WORD_W-1:0]    PC_4M,
    output logic [WORD_W-1:0]    ext_immM,
    output logic [WORD_W-1:0]    ReadDataM
);

    exMemCtrl_t        ctrlM;
    exMemData_t        dataM;
    logic [WORD_W-1:0] storeData;
    logic [ADDR_W-1:0] dmIndex;

    // ---------------------------------------------------------------------
    // EX/MEM pipeline register. Never stalls; bubbles arrive as zeros.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrlM <= '0;
            dataM <= '0;
        end else begin
            ctrlM.regWrite  <= RegWriteE;
            ctrlM.memtoReg  <= memtoReg_e'(MemtoRegE);
            ctrlM.memWrite  <= MemWriteE;
            ctrlM.writeReg  <= WriteRegE;
            ctrlM.tnew      <= tnewAge(TnewE);
            dataM.aluOut    <= ALUoutE;
            dataM.writeData <= WriteDataE;
            dataM.pc4       <= PC_4E;
            dataM.extImm    <= ext_immE;
        end
    end

    assign RegWriteM  = ctrlM.regWrite;
    assign MemtoRegM  = ctrlM.memtoReg;
    assign WriteRegM  = ctrlM.writeReg;
    assign TnewM      = ctrlM.tnew;
    assign ALUoutM    = dataM.aluOut;
    assign WriteDataM = dataM.writeData;
    assign PC_4M      = dataM.pc4;
    assign ext_immM   = dataM.extImm;

    // ---------------------------------------------------------------------
    // Store-data forwarding: a producer that has just reached Writeback
    // supplies the value the registered WriteDataM missed.
    // ---------------------------------------------------------------------
    always_comb begin
        storeData = dataM.writeData;
        if (forwardM) begin
            storeData = ResultW;
        end
    end

    // Word access: byte-offset bits and bits above the memory size are
    // dropped, so the index wraps modulo DM_WORDS.
    assign dmIndex = dataM.aluOut[ADDR_W+1:2];

    dm #(
        .DM_WORDS (DM_WORDS),
        .ADDR_W   (ADDR_W)
    ) uDm (
        .clk   (clk),
        .reset (reset),
        .we    (ctrlM.memWrite),
        .addr  (dmIndex),
        .wd    (storeData),
        .rd    (ReadDataM)
    );

endmodule : mem_stage

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter DM_WORDS, default 1024, number of 32-bit data-memory words (power of two).
REQ-002 SHALL have parameter ADDR_W, default 10, equal to log2(DM_WORDS); the word index is ALUoutM[ADDR_W+1:2].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 RegWriteE  input  1  register-write enable from Execute.
REQ-006 MemtoRegE  input  2  writeback-source select from Execute, passed through unchanged.
REQ-007 MemWriteE  input  1  store enable from Execute.
REQ-008 ALUoutE  input  32  ALU result (address or data) from Execute.
REQ-009 WriteDataE  input  32  store data from Execute.
REQ-010 WriteRegE  input  5  destination register from Execute.
REQ-011 PC_4E, ext_immE  input  32 each  PC+4 and extended immediate from Execute.
REQ-012 TnewE  input  2  cycles until result is ready, from Execute.
REQ-013 ResultW  input  32  writeback-stage result for store-data forwarding.
REQ-014 forwardM  input  1  1 = store data taken from ResultW, 0 = from registered WriteDataM.
REQ-015 RegWriteM, MemtoRegM[2], WriteRegM[5], TnewM[2]  output  registered control to Writeback and hazard unit.
REQ-016 ALUoutM, PC_4M, ext_immM  output  32 each  registered datapath values; ALUoutM also feeds Execute forwarding.
REQ-017 WriteDataM  output  32  registered store data (pre-forwarding), feeds the hazard unit.
REQ-018 ReadDataM  output  32  combinational data-memory read of the current word index.

Function
REQ-019 On each rising clk edge without reset, every E-input SHALL be captured into its M counterpart (one-cycle latency).
REQ-020 TnewM SHALL capture TnewE-1 when TnewE>0 and 0 when TnewE==0 (saturating, no wrap to 3).
REQ-021 Effective store data SHALL be ResultW when forwardM=1, else WriteDataM.
REQ-022 When MemWriteM=1, the memory word at ALUoutM[ADDR_W+1:2] SHALL be written with effective store data at the next rising edge.
REQ-023 ALUoutM[1:0] SHALL be ignored (word access only); address bits above ADDR_W+1 SHALL be ignored (index wraps modulo DM_WORDS).
REQ-024 ReadDataM SHALL reflect memory contents before a same-cycle write; a written value is visible from the cycle after the write edge.
REQ-025 A store and a new E capture on the same edge SHALL both occur; the store uses the pre-edge M registers.
REQ-026 The block SHALL never stall; stall/flush of Execute is handled upstream by presenting zeros (bubble) on E inputs.

Reset
REQ-027 When reset=1 at a rising edge, all M-register outputs SHALL become 0 (RegWriteM, MemtoRegM, WriteRegM, TnewM, ALUoutM, WriteDataM, PC_4M, ext_immM).
REQ-028 Reset SHALL clear every data-memory word to 0 at that edge, taking priority over any pending store.
REQ-029 Reset asserted mid-stream SHALL discard the in-flight instruction; the first capture after deassertion is the E values present at the first non-reset edge.

Structure
REQ-030 MemtoReg encodings (00 ALU, 01 memory, 10 PC+8) and the Tnew width SHALL live in the shared pipeline package, not in this module.
REQ-031 One sub-module dm (word-addressed memory, sync write, async read, sync clear) SHALL be instantiated; the EX/MEM register and forwarding mux remain in mem_stage.

Verification
REQ-032 Reset held 1 cycle with MemWriteE=1 pending -> all outputs 0, memory word 0 reads 0, no store.
REQ-033 E: MemWriteE=1, ALUoutE=0x0000_0008, WriteDataE=0x1234_5678, forwardM=0 -> cycle+1 ReadDataM still 0; cycle+2 with ALUoutE=0x8 captured, ReadDataM=0x1234_5678.
REQ-034 Store at ALUoutE=0x0000_100B (DM_WORDS=1024) -> writes word index 2; subsequent load at 0x8 returns stored value.
REQ-035 Store with forwardM=1, ResultW=0xDEAD_BEEF, WriteDataE=0x1 -> memory word holds 0xDEAD_BEEF; WriteDataM output shows 0x1.
REQ-036 TnewE sequence 2,1,0 -> TnewM 1,0,0 on successive cycles; RegWriteE=1, WriteRegE=5'd31, PC_4E=0x3004 -> RegWriteM=1, WriteRegM=31, PC_4M=0x3004 one cycle later.
